// File: rtl/alu_op_decoder_pkg.sv
// Shared ALU control codes, MIPS opcode/funct constants and the decoded
// micro-op type used by the instruction-to-ALU decode front end.
package alu_pkg;

   localparam logic [5:0] FUN_ADD = 6'b000000;
   localparam logic [5:0] FUN_SUB = 6'b000001;
   localparam logic [5:0] FUN_AND = 6'b011000;
   localparam logic [5:0] FUN_OR  = 6'b011110;
   localparam logic [5:0] FUN_XOR = 6'b010110;
   localparam logic [5:0] FUN_NOR = 6'b010001;
   localparam logic [5:0] FUN_SLL = 6'b100000;
   localparam logic [5:0] FUN_SRL = 6'b100001;
   localparam logic [5:0] FUN_SRA = 6'b100011;
   localparam logic [5:0] FUN_EQ  = 6'b110011;
   localparam logic [5:0] FUN_NEQ = 6'b110001;
   localparam logic [5:0] FUN_LT  = 6'b110101;
   localparam logic [5:0] FUN_LEZ = 6'b111101;
   localparam logic [5:0] FUN_LTZ = 6'b111011;
   localparam logic [5:0] FUN_GTZ = 6'b111111;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef struct packed {
      logic [5:0]  ALUFun;
      logic        Sign;
      logic        use_imm;
      logic [31:0] imm32;
      logic        use_shamt;
      logic [4:0]  shamt;
      logic        illegal;
   } uop_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// Instruction-in / micro-op-out handshake bundle between fetch, the decoder
// and the ALU operand stage.
interface alu_op_decoder_if #(
   parameter int TAG_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [5:0]       ALUFun;
   logic             Sign;
   logic             use_imm;
   logic [31:0]      imm32;
   logic             use_shamt;
   logic [4:0]       shamt;
   logic             illegal;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, ALUFun, Sign, use_imm, imm32,
             use_shamt, shamt, illegal, out_tag
   );

   modport slave (
      input  in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, ALUFun, Sign, use_imm, imm32,
             use_shamt, shamt, illegal, out_tag
   );
endinterface

// File: rtl/alu_op_decoder_decode_comb.sv
// Pure decode table: instruction fields to ALU micro-op. Only the opcode,
// rt and low halfword matter, so rs is not brought in.
module alu_op_decode_comb
   import alu_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [4:0]  rt,
   input  logic [15:0] imm,
   output uop_t        uop
);

   logic [5:0] funct;
   assign funct = imm[5:0];

   always_comb begin
      uop           = '0;
      uop.ALUFun    = FUN_ADD;
      uop.imm32     = sext16(imm);
      uop.shamt     = imm[10:6];
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  uop.Sign = 1'b1;
               FN_ADDU: uop.Sign = 1'b0;
               FN_SUB:  begin uop.ALUFun = FUN_SUB; uop.Sign = 1'b1; end
               FN_SUBU: uop.ALUFun = FUN_SUB;
               FN_AND:  uop.ALUFun = FUN_AND;
               FN_OR:   uop.ALUFun = FUN_OR;
               FN_XOR:  uop.ALUFun = FUN_XOR;
               FN_NOR:  uop.ALUFun = FUN_NOR;
               FN_SLT:  begin uop.ALUFun = FUN_LT; uop.Sign = 1'b1; end
               FN_SLTU: uop.ALUFun = FUN_LT;
               FN_SLL:  begin uop.ALUFun = FUN_SLL; uop.use_shamt = 1'b1; end
               FN_SRL:  begin uop.ALUFun = FUN_SRL; uop.use_shamt = 1'b1; end
               FN_SRA:  begin uop.ALUFun = FUN_SRA; uop.use_shamt = 1'b1; end
               FN_JR, FN_JALR: uop.Sign = 1'b0;
               default: uop.illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: begin
            uop.Sign    = 1'b1;
            uop.use_imm = 1'b1;
         end
         OP_ADDIU: uop.use_imm = 1'b1;
         OP_ANDI: begin
            uop.ALUFun  = FUN_AND;
            uop.use_imm = 1'b1;
            uop.imm32   = {16'h0, imm};
         end
         OP_ORI: begin
            uop.ALUFun  = FUN_OR;
            uop.use_imm = 1'b1;
            uop.imm32   = {16'h0, imm};
         end
         OP_SLTI: begin
            uop.ALUFun  = FUN_LT;
            uop.Sign    = 1'b1;
            uop.use_imm = 1'b1;
         end
         OP_SLTIU: begin
            uop.ALUFun  = FUN_LT;
            uop.use_imm = 1'b1;
         end
         OP_LUI: begin
            uop.use_imm = 1'b1;
            uop.imm32   = {imm, 16'h0};
         end
         // Branches compare rs against rt (or zero), never the immediate.
         OP_BEQ:  begin uop.ALUFun = FUN_EQ;  uop.Sign = 1'b1; end
         OP_BNE:  begin uop.ALUFun = FUN_NEQ; uop.Sign = 1'b1; end
         OP_BLEZ: begin uop.ALUFun = FUN_LEZ; uop.Sign = 1'b1; end
         OP_BGTZ: begin uop.ALUFun = FUN_GTZ; uop.Sign = 1'b1; end
         OP_REGIMM: begin
            if (rt == 5'd0) begin
               uop.ALUFun = FUN_LTZ;
               uop.Sign   = 1'b1;
            end else begin
               uop.illegal = 1'b1;
            end
         end
         OP_J, OP_JAL: uop.Sign = 1'b0;
         default: uop.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode front end: combinational decode into a 2-entry skid buffer so the
// producer sees a registered ready and full throughput survives backpressure.
module alu_op_decoder
   import alu_pkg::*;
#(
   parameter int TAG_W = 32,
   parameter int DEPTH = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   alu_op_decoder_if.slave  bus
);

   occ_t             state_q, state_d;
   uop_t             ent_q [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];
   uop_t             dec;
   logic             push, pop;
   logic             ld_head, ld_tail, shift;

   alu_op_decode_comb u_dec (
      .op  (bus.in_instr[31:26]),
      .rt  (bus.in_instr[20:16]),
      .imm (bus.in_instr[15:0]),
      .uop (dec)
   );

   // Ready comes from the state register only; out_ready never reaches it.
   assign bus.in_ready  = (state_q != FULL);
   assign bus.out_valid = (state_q != EMPTY);
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ld_head = 1'b0;
      ld_tail = 1'b0;
      shift   = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d = ONE;
                  ld_head = 1'b1;
               end
            end
            ONE: begin
               case ({push, pop})
                  2'b10: begin state_d = FULL;  ld_tail = 1'b1; end
                  2'b01: state_d = EMPTY;
                  2'b11: begin state_d = ONE;   ld_head = 1'b1; end
                  default: state_d = ONE;
               endcase
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  shift   = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Entry 0 is always the head; the tail slides forward when the head pops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         if (ld_head) begin
            ent_q[0] <= dec;
            tag_q[0] <= bus.in_tag;
         end else if (shift) begin
            ent_q[0] <= ent_q[1];
            tag_q[0] <= tag_q[1];
         end
         if (ld_tail) begin
            ent_q[1] <= dec;
            tag_q[1] <= bus.in_tag;
         end
      end
   end

   assign bus.ALUFun    = ent_q[0].ALUFun;
   assign bus.Sign      = ent_q[0].Sign;
   assign bus.use_imm   = ent_q[0].use_imm;
   assign bus.imm32     = ent_q[0].imm32;
   assign bus.use_shamt = ent_q[0].use_shamt;
   assign bus.shamt     = ent_q[0].shamt;
   assign bus.illegal   = ent_q[0].illegal;
   assign bus.out_tag   = tag_q[0];

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
Front-end producer for the datapath ALU. It accepts 32-bit MIPS instruction words on a valid/ready handshake and decodes each into the ALU control bundle: ALUFun, Sign, operand-B select, extended immediate and shamt. Decoded micro-ops are buffered in a 2-entry skid buffer, so a full-throughput stream is sustained under downstream backpressure. It sits between instruction fetch and the ALU operand-mux / execute stage.

Parameters:
TAG_W, 32, width of the opaque tag (normally the PC) carried alongside each instruction
DEPTH, 2, buffer entries; only the value 2 is supported

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous buffer clear, higher priority than push/pop
in_valid  in  1  instruction word present
in_ready  out  1  decoder can accept this cycle
in_instr  in  32  instruction word
in_tag  in  TAG_W  tag for in_instr
out_valid  out  1  head micro-op valid
out_ready  in  1  consumer accepts head
ALUFun  out  6  ALU function code
Sign  out  1  1 = signed compare/overflow semantics
use_imm  out  1  1 = B operand is imm32, 0 = rt
imm32  out  32  extended immediate
use_shamt  out  1  1 = A operand is shamt (shift ops)
shamt  out  5  instr[10:6]
illegal  out  1  unsupported encoding
out_tag  out  TAG_W  tag of head entry

Behaviour:
- ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
- Decode is combinational on in_instr and is stored on push.
- R-type (op 0x00), selected by funct:
  - 20 ADD S1; 21 ADD S0; 22 SUB S1; 23 SUB S0.
  - 24 AND; 25 OR; 26 XOR; 27 NOR.
  - 2A LT S1; 2B LT S0.
  - 00 SLL, 02 SRL, 03 SRA, each with use_shamt=1.
  - 08 jr and 09 jalr: ADD S0.
  - Any other funct: illegal.
- I-type, selected by op:
  - 08 ADD S1 sext; 09 ADD S0 sext.
  - 0C AND zext; 0D OR zext.
  - 0A LT S1 sext; 0B LT S0 sext.
  - 0F lui: ADD, imm32={imm,16'h0}.
  - 23/2B lw/sw: ADD S1 sext.
  - Branches, all S1 with use_imm=0: 04 EQ; 05 NEQ; 06 LEZ; 07 GTZ; 01 LTZ (only when rt=0, otherwise illegal).
  - 02/03 j/jal: ADD S0, illegal=0.
  - Any other op: illegal=1, ALUFun=ADD, Sign=0, use_imm=0, use_shamt=0.
- sext means imm32={{16{imm[15]}},imm}; zext means {16'h0,imm}. For R-type, imm32 = sext of instr[15:0] and is unused.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != 2), decoded from a register only, with no combinational path from out_ready.
  - out_valid = (count != 0). Output fields reflect the head entry.
- Occupancy state count ∈ {EMPTY=0, ONE=1, FULL=2}:
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push&pop → ONE, and the new entry becomes the head next cycle.
  - FULL: pop → ONE; push is impossible because in_ready=0.
- Latency: an accepted instruction appears at out_valid on the next rising edge. Throughput is 1/cycle while out_ready=1.
- Payload held at the output is stable while out_valid=1 and out_ready=0.
- flush: next state EMPTY; a push in the same cycle is discarded.
- Reset (asynchronous assert, synchronous release), entire period and first cycle after:
  - count=EMPTY, out_valid=0, in_ready=1.
  - All stored payload and output fields are 0, including ALUFun=000000.
- Reset asserted mid-operation discards all entries immediately.

Decomposition:
- Package alu_pkg holds:
  - localparams for the 15 ALUFun codes listed above;
  - opcode and funct constants;
  - a packed struct uop_t {ALUFun, Sign, use_imm, imm32, use_shamt, shamt, illegal}.
- One natural sub-module: alu_op_decode_comb, a pure decode table from instruction to uop_t. It is verified standalone against the table above.
- The top holds the 2-entry buffer and occupancy FSM.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 → out_valid=0, in_ready=1, ALUFun=000000 throughout. On release, the first push appears one cycle later.
- Decode sweep, out_ready=1:
  - 0x00221820 (add) → ALUFun 000000, Sign 1, use_imm 0.
  - 0x2402FFFF (addiu) → ADD, Sign 0, use_imm 1, imm32 FFFFFFFF.
  - 0x3C011234 (lui) → imm32 12340000.
  - 0x00021083 (sra) → 100011, use_shamt 1, shamt 2.
  - 0x0022182B (sltu) → 110101, Sign 0.
- Backpressure: push 3 back-to-back instructions with out_ready=0 → in_ready drops to 0 after 2 accepts. The third is held by the source. Raising out_ready drains in order with tags 0x0, 0x4, 0x8.
- Simultaneous push/pop at count ONE for 10 cycles → out_valid stays 1, in_ready stays 1, one micro-op per cycle, in order.
- Illegal encodings: 0xFC000000 (op 0x3F) and 0x04220000 (op 01, rt=2) → illegal 1, ALUFun 000000.
- flush with count FULL and in_valid=1 → next cycle out_valid=0, in_ready=1, and the pushed word is lost.
